// File: rtl/data_memory_pkg.sv
// Shared definitions for the L1 data cache and its backing data memory.
//  LINE_BITS           width of one cache line in bits
//  LINE_OFFSET_BITS    byte-offset bits inside a line (ignored by the memory)
//  MEM_LINE_INDEX_BITS line index bits of the default 512-line memory
//  state_t             memory-side handshake FSM encoding
package data_memory_pkg;

  localparam int LINE_BITS           = 256;
  localparam int LINE_OFFSET_BITS    = 5;
  localparam int MEM_LINE_INDEX_BITS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_if.sv
// Cache <-> data memory line bus.
//  enable_i  request valid, held by the cache until ack_o
//  write_i   1 = line write, 0 = line read
//  addr_i    byte address of the line
//  data_i    write line
//  ack_o     one-cycle completion pulse
//  data_o    read line, held until the next read completes
// master = cache side, slave = memory side.
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = LINE_BITS,
  parameter int ADDR_WIDTH = 32
);
  logic                  enable_i;
  logic                  write_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  ack_o;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/data_memory_array.sv
// Line storage for the data memory: DEPTH x DATA_WIDTH, single port.
//  clk_i   clock
//  we_i    write strobe; stores wdata_i at idx_i on the rising edge
//  idx_i   line index shared by read and write
//  wdata_i write line
//  rdata_o registered read line (value of mem[idx_i] before any write that edge)
// Contents are never reset.
module data_memory_array #(
  parameter  int DATA_WIDTH = 256,
  parameter  int DEPTH      = 512,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
    rdata_q <= mem[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Off-chip data memory behind the L1 data cache. Serves whole lines over the
// enable/write/ack handshake with a fixed LATENCY from accept to ack.
//  clk_i  clock, rising edge
//  rst_i  asynchronous active-low reset (control state and data_o only)
//  bus    data_memory_if slave: enable_i/write_i/addr_i/data_i in,
//         ack_o/data_o out
// LATENCY must lie in 1..255.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = LINE_BITS,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  data_memory_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam int         OFF_W    = LINE_OFFSET_BITS;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req_write_q, req_write_d;
  logic [IDX_W-1:0]      req_idx_q, req_idx_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;

  logic [IDX_W-1:0]      in_idx;
  logic [IDX_W-1:0]      arr_idx;
  logic                  arr_we;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  unused_addr_bits;

  // Byte offset and bits above the line index are don't-care: addresses wrap.
  assign in_idx           = bus.addr_i[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{bus.addr_i[ADDR_WIDTH-1:OFF_W+IDX_W], bus.addr_i[OFF_W-1:0]};

  // The array read is registered, so the address must be presented on the
  // edge that enters ACK. From IDLE (LATENCY==1) the request regs are only
  // being loaded on that edge, so the live bus index is used instead.
  assign arr_idx = (state_q == IDLE) ? in_idx : req_idx_q;
  // Commit happens on the edge leaving ACK; reset forces IDLE first, so an
  // interrupted write never lands.
  assign arr_we  = (state_q == ACK) && req_write_q;

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .idx_i   (arr_idx),
    .wdata_i (req_data_q),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    req_write_d = req_write_q;
    req_idx_d   = req_idx_q;
    req_data_d  = req_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          req_write_d = bus.write_i;
          req_idx_d   = in_idx;
          req_data_d  = bus.data_i;
          cnt_d       = CNT_LOAD;
          state_d     = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_write_q) begin
          rdata_d = arr_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == ACK);
  end

  // Control state and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      req_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      req_write_q <= req_write_d;
    end
  end

  // Request payload registers
  always_ff @(posedge clk_i) begin
    req_idx_q  <= req_idx_d;
    req_data_q <= req_data_d;
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int LAT   = 10;
  localparam int BOUND = 300;

  localparam logic [255:0] LINE_A5   = {32{8'hA5}};
  localparam logic [255:0] LINE_0123 = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] LINE_C1   = {8{32'hC1C1_0001}};
  localparam logic [255:0] LINE_C2   = {8{32'hC2C2_0002}};
  localparam logic [255:0] LINE_V4   = {8{32'h4444_0420}};
  localparam logic [255:0] LINE_V5   = {8{32'h5555_0005}};
  localparam logic [255:0] LINE_OLD  = {8{32'h0DD0_0080}};
  localparam logic [255:0] LINE_NEW  = {8{32'hBEEF_0080}};
  localparam logic [255:0] LINE_V6   = {8{32'h6666_0060}};
  localparam logic [255:0] LINE_JUNK = {8{32'hDEAD_DEAD}};

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [255:0] exp_dout;
  logic [255:0] exp_dout1;
  logic [255:0] sb [$];

  data_memory_if mif ();
  data_memory_if mif1 ();

  data_memory #(.LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (mif)
  );

  data_memory #(.LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (mif1)
  );

  always #5 clk = ~clk;

  // Protocol: the cache must hold enable_i while a request is in flight.
  always @(negedge clk) begin
    if (rst_n && dut.state_q == WAIT) begin
      assert (mif.enable_i) else $error("enable_i dropped during WAIT");
    end
  end

  task automatic txn(input logic wr, input logic [31:0] a, input logic [255:0] wd,
                     input logic [255:0] rd_exp, input string nm);
    int lat;
    logic [255:0] exp;
    sb.push_back(wr ? exp_dout : rd_exp);
    mif.enable_i = 1'b1; mif.write_i = wr; mif.addr_i = a; mif.data_i = wd;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!mif.ack_o && lat < BOUND);
    mif.enable_i = 1'b0; mif.write_i = 1'b0;
    n_checks++;
    if (lat !== LAT) begin
      n_err++; $display("FAIL %s_latency: got %0d cycles expected %0d", nm, lat, LAT);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mif.ack_o !== 1'b0) begin
      n_err++; $display("FAIL %s_ack_pulse: ack_o got %b expected 0", nm, mif.ack_o);
    end
    exp = sb.pop_front();
    n_checks++;
    if (mif.data_o !== exp) begin
      n_err++; $display("FAIL %s_data: got %h expected %h", nm, mif.data_o, exp);
    end
    exp_dout = exp;
  endtask

  task automatic txn1(input logic wr, input logic [31:0] a, input logic [255:0] wd,
                      input logic [255:0] rd_exp, input string nm);
    int lat;
    logic [255:0] exp;
    sb.push_back(wr ? exp_dout1 : rd_exp);
    mif1.enable_i = 1'b1; mif1.write_i = wr; mif1.addr_i = a; mif1.data_i = wd;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!mif1.ack_o && lat < BOUND);
    mif1.enable_i = 1'b0; mif1.write_i = 1'b0;
    n_checks++;
    if (lat !== 1) begin
      n_err++; $display("FAIL %s_latency: got %0d cycles expected 1", nm, lat);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mif1.ack_o !== 1'b0) begin
      n_err++; $display("FAIL %s_ack_pulse: ack_o got %b expected 0", nm, mif1.ack_o);
    end
    exp = sb.pop_front();
    n_checks++;
    if (mif1.data_o !== exp) begin
      n_err++; $display("FAIL %s_data: got %h expected %h", nm, mif1.data_o, exp);
    end
    exp_dout1 = exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mif.enable_i  = 1'b0; mif.write_i  = 1'b0; mif.addr_i  = '0; mif.data_i  = '0;
    mif1.enable_i = 1'b0; mif1.write_i = 1'b0; mif1.addr_i = '0; mif1.data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_dout = '0; exp_dout1 = '0;
    @(posedge clk); #1;
    // Preload line 2, then reset again: the array must survive reset.
    txn(1'b1, 32'h0000_0040, LINE_A5, '0, "preload_line2");
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mif.ack_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ack: got %b expected 0", mif.ack_o);
    end
    n_checks++;
    if (mif.data_o !== '0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", mif.data_o);
    end
    n_checks++;
    if (mif1.ack_o !== 1'b0 || mif1.data_o !== '0) begin
      n_err++; $display("FAIL reset_dut1: ack %b data %h expected 0/0", mif1.ack_o, mif1.data_o);
    end
    rst_n = 1'b1;
    exp_dout = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read();
    txn(1'b0, 32'h0000_0040, '0, LINE_A5, "read_line2");
  endtask

  task automatic test_raw();
    txn(1'b1, 32'h0000_0400, LINE_0123, '0, "write_0400");
    txn(1'b0, 32'h0000_0400, '0, LINE_0123, "read_0400");
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [255:0] exp;
    txn(1'b1, 32'h0000_2000, LINE_C2, '0, "chain_preload");
    sb.push_back(exp_dout);
    mif.enable_i = 1'b1; mif.write_i = 1'b1; mif.addr_i = 32'h0000_1000; mif.data_i = LINE_C1;
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!mif.ack_o && cnt < BOUND);
    n_checks++;
    if (cnt !== LAT) begin
      n_err++; $display("FAIL chain_wr_latency: got %0d expected %0d", cnt, LAT);
    end
    // Enable stays high; the follow-on read is presented right after the ack.
    mif.write_i = 1'b0; mif.addr_i = 32'h0000_2000; mif.data_i = LINE_JUNK;
    sb.push_back(LINE_C2);
    @(posedge clk); #1;
    cnt = 1;
    exp = sb.pop_front();
    n_checks++;
    if (mif.data_o !== exp) begin
      n_err++; $display("FAIL chain_wr_data: got %h expected %h", mif.data_o, exp);
    end
    while (!mif.ack_o && cnt < BOUND) begin
      @(posedge clk); #1; cnt++;
    end
    n_checks++;
    if (cnt !== LAT + 1) begin
      n_err++; $display("FAIL chain_ack_gap: got %0d expected %0d", cnt, LAT + 1);
    end
    mif.enable_i = 1'b0;
    @(posedge clk); #1;
    exp = sb.pop_front();
    n_checks++;
    if (mif.data_o !== exp) begin
      n_err++; $display("FAIL chain_rd_data: got %h expected %h", mif.data_o, exp);
    end
    exp_dout = exp;
    txn(1'b0, 32'h0000_1000, '0, LINE_C1, "chain_verify_1000");
  endtask

  task automatic test_addr_wrap();
    txn(1'b1, 32'h0000_4020, LINE_V4, '0, "write_4020");
    txn(1'b0, 32'h0000_0020, '0, LINE_V4, "read_0020_alias");
    txn(1'b1, 32'h0000_0005, LINE_V5, '0, "write_0005");
    txn(1'b0, 32'h0000_001F, '0, LINE_V5, "read_001f");
    txn(1'b0, 32'h0000_0000, '0, LINE_V5, "read_0000");
  endtask

  task automatic test_reset_abort();
    int acks;
    int cnt;
    txn(1'b1, 32'h0000_0080, LINE_OLD, '0, "write_old_0080");
    // Reset in the middle of WAIT.
    mif.enable_i = 1'b1; mif.write_i = 1'b1; mif.addr_i = 32'h0000_0080; mif.data_i = LINE_NEW;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; mif.enable_i = 1'b0; mif.write_i = 1'b0;
    #1;
    n_checks++;
    if (mif.ack_o !== 1'b0 || mif.data_o !== '0) begin
      n_err++; $display("FAIL rst_wait_outputs: ack %b data %h expected 0/0", mif.ack_o, mif.data_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_dout = '0;
    acks = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (mif.ack_o) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_err++; $display("FAIL rst_wait_no_ack: got %0d acks expected 0", acks);
    end
    // Reset during the ACK cycle itself.
    mif.enable_i = 1'b1; mif.write_i = 1'b1; mif.addr_i = 32'h0000_0080; mif.data_i = LINE_NEW;
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!mif.ack_o && cnt < BOUND);
    rst_n = 1'b0; mif.enable_i = 1'b0; mif.write_i = 1'b0;
    #1;
    n_checks++;
    if (cnt !== LAT || mif.ack_o !== 1'b0) begin
      n_err++; $display("FAIL rst_ack_drop: latency %0d ack %b expected %0d/0", cnt, mif.ack_o, LAT);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h0000_0080, '0, LINE_OLD, "read_0080_kept");
  endtask

  task automatic test_latency_one();
    txn1(1'b1, 32'h0000_0060, LINE_V6, '0, "l1_write_0060");
    txn1(1'b0, 32'h0000_0060, '0, LINE_V6, "l1_read_0060");
    txn1(1'b0, 32'h0000_0000, '0, LINE_V6 ^ LINE_V6 ^ exp_dout1 ^ exp_dout1 ^ LINE_V6 ^ LINE_V6, "l1_dummy")
      ;
  endtask

  task automatic test_wait_inputs_ignored();
    int cnt;
    logic [255:0] exp;
    sb.push_back(LINE_A5);
    mif.enable_i = 1'b1; mif.write_i = 1'b0; mif.addr_i = 32'h0000_0040; mif.data_i = '0;
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
      if (cnt == 3) begin
        mif.addr_i = 32'h0000_0400; mif.write_i = 1'b1; mif.data_i = LINE_JUNK;
      end
    end while (!mif.ack_o && cnt < BOUND);
    mif.enable_i = 1'b0; mif.write_i = 1'b0;
    n_checks++;
    if (cnt !== LAT) begin
      n_err++; $display("FAIL ignore_latency: got %0d expected %0d", cnt, LAT);
    end
    @(posedge clk); #1;
    exp = sb.pop_front();
    n_checks++;
    if (mif.data_o !== exp) begin
      n_err++; $display("FAIL ignore_data: got %h expected %h", mif.data_o, exp);
    end
    exp_dout = exp;
    txn(1'b0, 32'h0000_0400, '0, LINE_0123, "ignore_0400_intact");
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_raw();
    test_back_to_back();
    test_addr_wrap();
    test_reset_abort();
    test_latency_one();
    test_wait_inputs_ignored();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
